// File: rtl/pkt_parser.sv
// Ethernet II / IPv4 / TCP-UDP header parser that turns a byte stream into one
// feature vector per packet, presented as a single-cycle pkt_valid pulse.
module pkt_parser #(
    parameter int DATA_WIDTH = 32,
    parameter int N_FEATURES = 28,
    parameter int MAX_LEN    = 16383
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [7:0]                           s_data,
    input  logic                                 s_valid,
    input  logic                                 s_sop,
    input  logic                                 s_eop,
    output logic                                 s_ready,
    output logic [N_FEATURES-1:0][DATA_WIDTH-1:0] pkt_features,
    output logic                                 pkt_valid
);

    localparam int              LEN_W   = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, HDR, SKIP, EMIT} state_t;

    function automatic logic [7:0] off_inc(input logic [7:0] v);
        return (&v) ? v : v + 8'd1;
    endfunction

    function automatic logic [LEN_W-1:0] len_inc(input logic [LEN_W-1:0] v);
        return (v >= LEN_MAX) ? LEN_MAX : v + LEN_W'(1);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] cnt_inc(input logic [DATA_WIDTH-1:0] v);
        return (&v) ? v : v + DATA_WIDTH'(1);
    endfunction

    state_t                               state_q, state_d;
    logic [7:0]                           off_q, off_d, l4_q, l4_d;
    logic [LEN_W-1:0]                     len_q, len_d;
    logic [DATA_WIDTH-1:0]                cnt_q, cnt_d, ia_q, ia_d;
    logic                                 first_q, first_d;
    logic [15:0]                          et_q, et_d, tlen_q, tlen_d;
    logic [15:0]                          sport_q, sport_d, dport_q, dport_d;
    logic [7:0]                           vihl_q, vihl_d, ttl_q, ttl_d;
    logic [7:0]                           proto_q, proto_d, flags_q, flags_d;
    logic [31:0]                          sip_q, sip_d, dip_q, dip_d;
    logic [N_FEATURES-1:0][DATA_WIDTH-1:0] feat_q, feat_d;

    logic       accept, emit, is_l4;
    logic [7:0] cur_off, need;
    logic [15:0] et_v;
    logic       ip_hdr, is_ipv4, malformed;

    assign s_ready      = (state_q != EMIT);
    assign pkt_valid    = (state_q == EMIT);
    assign pkt_features = feat_q;
    assign accept       = s_valid && s_ready;
    assign is_l4        = (proto_q == 8'd6) || (proto_q == 8'd17);

    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        l4_d    = l4_q;
        len_d   = len_q;
        cnt_d   = cnt_inc(cnt_q);
        ia_d    = ia_q;
        first_d = first_q;
        et_d    = et_q;
        tlen_d  = tlen_q;
        sport_d = sport_q;
        dport_d = dport_q;
        vihl_d  = vihl_q;
        ttl_d   = ttl_q;
        proto_d = proto_q;
        flags_d = flags_q;
        sip_d   = sip_q;
        dip_d   = dip_q;
        cur_off = off_q;
        emit    = 1'b0;
        if (state_q == EMIT) state_d = IDLE;
        if (accept) begin
            if (s_sop) begin
                // A sop anywhere restarts parsing; an unfinished packet is simply dropped.
                state_d = HDR;
                cur_off = 8'd0;
                off_d   = 8'd1;
                l4_d    = 8'd34;
                len_d   = LEN_W'(1);
                ia_d    = first_q ? '0 : cnt_q;
                cnt_d   = DATA_WIDTH'(1);
                first_d = 1'b0;
                et_d    = '0;
                tlen_d  = '0;
                sport_d = '0;
                dport_d = '0;
                vihl_d  = '0;
                ttl_d   = '0;
                proto_d = '0;
                flags_d = '0;
                sip_d   = '0;
                dip_d   = '0;
                emit    = s_eop;
            end else if (state_q != IDLE) begin
                off_d = off_inc(off_q);
                len_d = len_inc(len_q);
                if (state_q == HDR) begin
                    case (off_q)
                        8'd12: et_d[15:8]    = s_data;
                        8'd13: et_d[7:0]     = s_data;
                        8'd14: begin
                            vihl_d = s_data;
                            l4_d   = 8'd14 + {2'b00, s_data[3:0], 2'b00};
                        end
                        8'd16: tlen_d[15:8]  = s_data;
                        8'd17: tlen_d[7:0]   = s_data;
                        8'd22: ttl_d         = s_data;
                        8'd23: proto_d       = s_data;
                        8'd26: sip_d[31:24]  = s_data;
                        8'd27: sip_d[23:16]  = s_data;
                        8'd28: sip_d[15:8]   = s_data;
                        8'd29: sip_d[7:0]    = s_data;
                        8'd30: dip_d[31:24]  = s_data;
                        8'd31: dip_d[23:16]  = s_data;
                        8'd32: dip_d[15:8]   = s_data;
                        8'd33: dip_d[7:0]    = s_data;
                        default: ;
                    endcase
                    if (is_l4) begin
                        if (off_q == l4_q)          sport_d[15:8] = s_data;
                        if (off_q == l4_q + 8'd1)   sport_d[7:0]  = s_data;
                        if (off_q == l4_q + 8'd2)   dport_d[15:8] = s_data;
                        if (off_q == l4_q + 8'd3)   dport_d[7:0]  = s_data;
                    end
                    if (proto_q == 8'd6 && off_q == l4_q + 8'd13) flags_d = s_data;
                    if (off_q == l4_q + 8'd13) state_d = SKIP;
                end
                emit = s_eop;
            end
        end
        if (emit) state_d = EMIT;
    end

    // Field validity is judged against the offset of the eop byte, so partially received fields read 0.
    assign et_v      = (cur_off >= 8'd13) ? et_d : 16'h0000;
    assign ip_hdr    = (et_v == 16'h0800);
    assign is_ipv4   = ip_hdr && (vihl_d[7:4] == 4'd4) && (vihl_d[3:0] >= 4'd5);
    assign need      = (proto_d == 8'd6)  ? l4_d + 8'd13 :
                       (proto_d == 8'd17) ? l4_d + 8'd3  : 8'd33;
    assign malformed = (cur_off < 8'd13) || (ip_hdr && !is_ipv4) || (is_ipv4 && cur_off < need);

    always_comb begin
        feat_d = feat_q;
        if (emit) begin
            feat_d     = '0;
            feat_d[0]  = DATA_WIDTH'(len_d);
            feat_d[1]  = DATA_WIDTH'(et_v);
            feat_d[12] = ia_d;
            feat_d[13] = DATA_WIDTH'(malformed);
            if (is_ipv4) begin
                feat_d[2]  = DATA_WIDTH'(proto_d);
                feat_d[3]  = DATA_WIDTH'(ttl_d);
                feat_d[4]  = (cur_off >= 8'd29) ? DATA_WIDTH'(sip_d) : '0;
                feat_d[5]  = (cur_off >= 8'd33) ? DATA_WIDTH'(dip_d) : '0;
                feat_d[6]  = (cur_off >= l4_d + 8'd1) ? DATA_WIDTH'(sport_d) : '0;
                feat_d[7]  = (cur_off >= l4_d + 8'd3) ? DATA_WIDTH'(dport_d) : '0;
                feat_d[8]  = DATA_WIDTH'(flags_d);
                feat_d[9]  = (cur_off >= 8'd17) ? DATA_WIDTH'(tlen_d) : '0;
                feat_d[10] = DATA_WIDTH'({vihl_d[3:0], 2'b00});
                feat_d[11] = DATA_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            off_q   <= '0;
            l4_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            ia_q    <= '0;
            first_q <= 1'b1;
            et_q    <= '0;
            tlen_q  <= '0;
            sport_q <= '0;
            dport_q <= '0;
            vihl_q  <= '0;
            ttl_q   <= '0;
            proto_q <= '0;
            flags_q <= '0;
            sip_q   <= '0;
            dip_q   <= '0;
            feat_q  <= '0;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            l4_q    <= l4_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            ia_q    <= ia_d;
            first_q <= first_d;
            et_q    <= et_d;
            tlen_q  <= tlen_d;
            sport_q <= sport_d;
            dport_q <= dport_d;
            vihl_q  <= vihl_d;
            ttl_q   <= ttl_d;
            proto_q <= proto_d;
            flags_q <= flags_d;
            sip_q   <= sip_d;
            dip_q   <= dip_d;
            feat_q  <= feat_d;
        end
    end

endmodule

// File: tb/tb_pkt_parser.sv
// Scoreboard bench for pkt_parser: expected feature vectors are queued as each
// eop is accepted and compared when pkt_valid appears.
module tb_pkt_parser;

    localparam int DW = 32;
    localparam int NF = 28;
    localparam int ML = 16383;

    typedef logic [13:0][31:0] fvec_t;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [7:0]               s_data;
    logic                     s_valid, s_sop, s_eop;
    logic                     s_ready;
    logic [NF-1:0][DW-1:0]    pkt_features;
    logic                     pkt_valid;

    always #5 clk = ~clk;

    pkt_parser #(.DATA_WIDTH(DW), .N_FEATURES(NF), .MAX_LEN(ML)) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid),
        .s_sop(s_sop), .s_eop(s_eop), .s_ready(s_ready),
        .pkt_features(pkt_features), .pkt_valid(pkt_valid)
    );

    int   n_vec = 0, n_err = 0, n_emit = 0;
    int   cyc = 0, emit_cyc = -10, last_sop_cyc = 0, ia_cur = 0, nb = 0;
    bit   first_sop = 1'b1, in_pkt = 1'b0;
    logic [7:0] pb [0:127];
    logic [7:0] rb [0:127];
    fvec_t exp_q [$];
    int    cyc_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference: features of the n bytes received since the last sop.
    function automatic fvec_t model(input int n, input int ia);
        fvec_t f;
        int fo, l4, need;
        logic [15:0] et;
        logic [7:0] proto;
        f = '0;
        fo = n - 1;
        f[0] = 32'((n > ML) ? ML : n);
        et = (fo >= 13) ? {rb[12], rb[13]} : 16'h0000;
        f[1] = 32'(et);
        f[12] = 32'(ia);
        f[13] = 32'(fo < 13);
        if (et == 16'h0800) begin
            if (fo < 14 || rb[14][7:4] != 4'd4 || rb[14][3:0] < 4'd5) begin
                f[13] = 32'd1;
            end else begin
                l4 = 14 + 4 * int'(rb[14][3:0]);
                proto = (fo >= 23) ? rb[23] : 8'h00;
                f[2] = 32'(proto);
                f[3] = (fo >= 22) ? 32'(rb[22]) : 32'd0;
                f[4] = (fo >= 29) ? {rb[26], rb[27], rb[28], rb[29]} : 32'd0;
                f[5] = (fo >= 33) ? {rb[30], rb[31], rb[32], rb[33]} : 32'd0;
                if (proto == 8'd6 || proto == 8'd17) begin
                    f[6] = (fo >= l4 + 1) ? {16'h0, rb[l4], rb[l4+1]} : 32'd0;
                    f[7] = (fo >= l4 + 3) ? {16'h0, rb[l4+2], rb[l4+3]} : 32'd0;
                end
                if (proto == 8'd6 && fo >= l4 + 13) f[8] = 32'(rb[l4+13]);
                f[9]  = (fo >= 17) ? {16'h0, rb[16], rb[17]} : 32'd0;
                f[10] = 32'(4 * int'(rb[14][3:0]));
                f[11] = 32'd1;
                need = (proto == 8'd6) ? l4 + 13 : (proto == 8'd17) ? l4 + 3 : 33;
                if (fo < need) f[13] = 32'd1;
            end
        end
        return f;
    endfunction

    task automatic send_byte(input logic [7:0] d, input bit sop, input bit eop, output int tries);
        bit acc;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 8) begin
            @(negedge clk);
            s_data = d; s_valid = 1'b1; s_sop = sop; s_eop = eop;
            check("s_ready", 32'(s_ready), (cyc == emit_cyc) ? 32'd0 : 32'd1);
            acc = s_ready;
            tries++;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            check("accept_timeout", 32'(acc), 32'd1);
        end else begin
            if (sop) begin
                ia_cur = first_sop ? 0 : cyc - last_sop_cyc;
                first_sop = 1'b0;
                last_sop_cyc = cyc;
                in_pkt = 1'b1;
                nb = 0;
            end
            if (in_pkt) begin
                if (nb < 128) rb[nb] = d;
                nb++;
                if (eop) begin
                    exp_q.push_back(model(nb, ia_cur));
                    cyc_q.push_back(cyc);
                    emit_cyc = cyc;
                    in_pkt = 1'b0;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
        end
    endtask

    task automatic send_pkt(input int len, input int gap, output int first_tries);
        int t;
        first_tries = 0;
        for (int i = 0; i < len; i++) begin
            send_byte(pb[i], i == 0, i == len - 1, t);
            if (i == 0) first_tries = t;
        end
        if (gap > 0) idle(gap);
    endtask

    task automatic fill(input int seed);
        for (int i = 0; i < 128; i++) pb[i] = 8'(i * 13 + seed);
    endtask

    task automatic build_ip(input logic [3:0] ver, input logic [3:0] ihl, input logic [7:0] proto,
                            input logic [7:0] ttl, input logic [15:0] tlen,
                            input logic [31:0] sip, input logic [31:0] dip,
                            input logic [15:0] sp, input logic [15:0] dp, input logic [7:0] flags);
        int l4;
        fill(5);
        pb[12] = 8'h08; pb[13] = 8'h00; pb[14] = {ver, ihl};
        pb[16] = tlen[15:8]; pb[17] = tlen[7:0]; pb[22] = ttl; pb[23] = proto;
        pb[26] = sip[31:24]; pb[27] = sip[23:16]; pb[28] = sip[15:8]; pb[29] = sip[7:0];
        pb[30] = dip[31:24]; pb[31] = dip[23:16]; pb[32] = dip[15:8]; pb[33] = dip[7:0];
        l4 = 14 + 4 * int'(ihl);
        pb[l4] = sp[15:8]; pb[l4+1] = sp[7:0]; pb[l4+2] = dp[15:8]; pb[l4+3] = dp[7:0];
        pb[l4+13] = flags;
    endtask

    task automatic build_tcp();
        build_ip(4'd4, 4'd5, 8'd6, 8'd64, 16'd50, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80, 8'h12);
    endtask

    always @(negedge clk) begin : monitor
        fvec_t e;
        int c;
        if (pkt_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 32'(pkt_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                c = cyc_q.pop_front();
                n_emit++;
                check("emit_cycle", 32'(cyc), 32'(c));
                check("ready_in_emit", 32'(s_ready), 32'd0);
                for (int i = 0; i < 14; i++) check($sformatf("f%0d", i), pkt_features[i], e[i]);
                check("f14", pkt_features[14], 32'd0);
                check("f27", pkt_features[NF-1], 32'd0);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
        $fatal(1);
    end

    initial begin : main
        int t;
        int emits_before;
        rst_n = 1'b1; s_data = '0; s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NF; i++) check($sformatf("rst_f%0d", i), pkt_features[i], 32'd0);
        check("rst_valid", 32'(pkt_valid), 32'd0);
        check("rst_ready", 32'(s_ready), 32'd1);
        rst_n = 1'b1;
        idle(2);

        build_tcp();
        send_pkt(64, 3, t);
        check("tcp_len", pkt_features[0], 32'd64);
        check("tcp_et", pkt_features[1], 32'h0800);
        check("tcp_sip", pkt_features[4], 32'h0A000001);
        check("tcp_sport", pkt_features[6], 32'd1234);
        check("tcp_flags", pkt_features[8], 32'h12);
        check("tcp_ihl4", pkt_features[10], 32'd20);

        build_ip(4'd4, 4'd6, 8'd17, 8'd32, 16'd60, 32'hC0A80001, 32'hC0A80002, 16'd5000, 16'd53, 8'hFF);
        send_pkt(64, 3, t);
        check("udp_proto", pkt_features[2], 32'd17);
        check("udp_flags", pkt_features[8], 32'd0);
        check("udp_ihl4", pkt_features[10], 32'd24);
        check("udp_dport", pkt_features[7], 32'd53);

        fill(9); pb[12] = 8'h08; pb[13] = 8'h06;
        send_pkt(60, 3, t);
        check("arp_len", pkt_features[0], 32'd60);
        check("arp_et", pkt_features[1], 32'h0806);
        check("arp_ipv4", pkt_features[11], 32'd0);
        check("arp_mal", pkt_features[13], 32'd0);

        build_tcp();
        send_pkt(26, 3, t);
        check("trunc_mal", pkt_features[13], 32'd1);
        check("trunc_ttl", pkt_features[3], 32'd64);
        check("trunc_sip", pkt_features[4], 32'd0);
        check("trunc_len", pkt_features[0], 32'd26);

        build_ip(4'd6, 4'd5, 8'd6, 8'd64, 16'd50, 32'h01020304, 32'h05060708, 16'd1, 16'd2, 8'h02);
        send_pkt(64, 3, t);
        check("badver_mal", pkt_features[13], 32'd1);
        check("badver_ipv4", pkt_features[11], 32'd0);

        emits_before = n_emit;
        send_byte(8'hAA, 1'b0, 1'b0, t);
        send_byte(8'hBB, 1'b0, 1'b1, t);
        idle(3);
        check("idle_drop", 32'(n_emit), 32'(emits_before));

        build_tcp();
        for (int i = 0; i < 20; i++) send_byte(pb[i], i == 0, 1'b0, t);
        send_pkt(64, 3, t);
        check("abort_ia", pkt_features[12], 32'd20);
        check("abort_emits", 32'(n_emit), 32'(emits_before + 1));

        send_pkt(64, 0, t);
        send_pkt(64, 3, t);
        check("b2b_tries", 32'(t), 32'd2);
        check("b2b_ia", pkt_features[12], 32'd65);

        pb[0] = 8'h5A;
        send_pkt(1, 3, t);
        check("single_len", pkt_features[0], 32'd1);
        check("single_mal", pkt_features[13], 32'd1);

        build_tcp();
        for (int i = 0; i < 30; i++) send_byte(pb[i], i == 0, 1'b0, t);
        @(negedge clk);
        s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NF; i++) check($sformatf("midrst_f%0d", i), pkt_features[i], 32'd0);
        check("midrst_valid", 32'(pkt_valid), 32'd0);
        check("midrst_ready", 32'(s_ready), 32'd1);
        in_pkt = 1'b0; first_sop = 1'b1; emit_cyc = -10;
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        fill(9); pb[12] = 8'h08; pb[13] = 8'h06;
        send_pkt(60, 3, t);
        check("postrst_ia", pkt_features[12], 32'd0);

        idle(5);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        check("emit_count", 32'(n_emit), 32'd10);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pkt_parser.md
Name: pkt_parser

Overview:
- Upstream neighbour of the feature extraction stage; converts a raw Ethernet byte stream into a per-packet feature vector.
- Parses Ethernet II, IPv4 and the first TCP/UDP header bytes.
- Drives a one-cycle-valid feature array whose shape matches the feature extraction stage input (pkt_features / pkt_valid).
- Output has no backpressure; the consumer always accepts.

Parameters:
- DATA_WIDTH, 32, width of each feature word.
- N_FEATURES, 28, number of feature words (must be ≥ 14).
- MAX_LEN, 16383, saturation value for the byte counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- s_data  in  8  stream byte
- s_valid  in  1  byte valid
- s_sop  in  1  first byte of packet (qualified by s_valid)
- s_eop  in  1  last byte of packet (qualified by s_valid)
- s_ready  out  1  byte accepted when s_valid && s_ready
- pkt_features  out  DATA_WIDTH x N_FEATURES  feature vector, zero-extended fields
- pkt_valid  out  1  one-cycle pulse, vector valid

Behaviour:
- Reset (async): all pkt_features = 0; pkt_valid = 0; s_ready = 1; state = IDLE; counters = 0; first-packet flag set.
- States:
  - IDLE: accepts only sop bytes; non-sop bytes are consumed and dropped.
  - HDR: header byte capture.
  - SKIP: payload bytes counted, not parsed.
  - EMIT: one cycle.
- Transitions:
  - IDLE → HDR on an accepted sop.
  - HDR → SKIP once byte offset l4_off+13 is captured.
  - HDR/SKIP → EMIT on an accepted eop.
  - EMIT → IDLE.
- Byte offset counter off starts at 0 on the sop byte and increments per accepted byte.
- Length counter: 1 on the sop byte, +1 per byte, saturates at MAX_LEN.
- Capture (big-endian): ethertype off 12-13; IPv4 fields valid only if ethertype = 0x0800.
  - ver/IHL at off 14; total_len 16-17; TTL 22; protocol 23; src_ip 26-29; dst_ip 30-33.
  - l4_off = 14 + IHL*4.
  - Ports at l4_off+0..3 when protocol is 6 or 17.
  - TCP flags at l4_off+13 only when protocol = 6.
- Feature index map (all other indices drive 0):
  - 0 = byte length
  - 1 = ethertype
  - 2 = protocol
  - 3 = TTL
  - 4 = src_ip
  - 5 = dst_ip
  - 6 = src_port
  - 7 = dst_port
  - 8 = TCP flags
  - 9 = IP total_len
  - 10 = IHL*4
  - 11 = is_ipv4
  - 12 = inter-arrival cycles
  - 13 = malformed
- Inter-arrival:
  - Free-running cycle counter, saturating at all-ones.
  - Sampled and cleared on each accepted sop.
  - First packet after reset reports 0.
- Output timing: pkt_valid = 1 exactly in the cycle after the eop byte is accepted (EMIT).
  - pkt_features update in that same cycle and hold until the next EMIT.
  - s_ready = 0 during EMIT only; 1 in all other states.
- Non-IPv4 ethertype: indices 2-10 = 0; is_ipv4 = 0; malformed = 0.
- Malformed = 1 (fields not fully received stay 0) if any of:
  - ethertype 0x0800 with version ≠ 4 or IHL < 5 (then is_ipv4 = 0 and indices 2-10 = 0);
  - eop before the last required header byte (off 13, off 33, or the needed L4 byte);
  - sop and eop on the same byte.
- sop accepted while in HDR or SKIP: current packet is aborted with no emit; parsing restarts with this byte as off 0; inter-arrival is sampled normally.
- Header fields are captured into working registers and copied to the outputs only at EMIT. An aborted packet never disturbs the held outputs.
- Reset mid-packet: immediate return to the reset state; no emit.

Test Plan:
- 64-byte IPv4/TCP packet: IHL 5, src 10.0.0.1, dst 10.0.0.2, ports 1234→80, flags 0x12, TTL 64, total_len 50.
  - Expect one pkt_valid the cycle after eop.
  - Expect [0]=64, [1]=0x0800, [2]=6, [3]=64, [4]=0x0A000001, [5]=0x0A000002, [6]=1234, [7]=80, [8]=0x12, [9]=50, [10]=20, [11]=1, [13]=0.
- IPv4/UDP with IHL 6: ports read at off 38-41; [2]=17; [8]=0; [10]=24.
- ARP frame (0x0806), 60 bytes: [0]=60, [1]=0x0806, [2..11]=0, [13]=0.
- Truncated IPv4 frame, eop at off 25: [13]=1; [3] captured; [4]=[5]=0; [0]=26.
- Second sop at byte 20 of a packet, then a clean 64-byte packet:
  - Exactly one pkt_valid.
  - Inter-arrival = cycles between the two sops.
  - s_ready low only in the EMIT cycle.
- Back-to-back packets, sop arriving in the EMIT cycle: byte not accepted (s_ready = 0), accepted next cycle. Also assert rst_n mid-packet: no pkt_valid, and all outputs = 0.
